// File: rtl/uart_fifo_mmio.sv
// MMIO UART with TX/RX FIFOs, runtime baud divisor, sticky W1C error flags and a level irq.
// The synchronous byte FIFO used for both directions is defined first.

// Byte FIFO with occupancy count and single-cycle flush.
// Latency: a push is visible at head_o on the next cycle.
// Backpressure: a push to a full FIFO is dropped unless a pop happens in the same cycle.
module uart_fifo_mmio_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] push_dat_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic [7:0] lvl_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rptr_q, wptr_q;
  logic [AW:0]   cnt_q;
  logic [31:0]   cnt_ext;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop | flush_i);
  assign head_o  = empty_o ? 8'h00 : mem_q[rptr_q];
  assign cnt_ext = 32'(cnt_q);
  assign lvl_o   = (cnt_ext > 32'd255) ? 8'hFF : cnt_ext[7:0];

  // A push in the flush cycle lands as the first entry of the emptied FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= AW'(push_i);
      cnt_q  <= (AW+1)'(push_i);
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[flush_i ? '0 : wptr_q] <= push_dat_i;
  end
endmodule

// UART register block with built-in 8N1 TX/RX engines.
// Latency: TXDATA write into an idle, empty TX path drives the start bit 2 cycles later.
// Backpressure: none on the bus; full-FIFO pushes are dropped and flagged sticky.
module uart_fifo_mmio #(
  parameter int CLK_FRE   = 27,
  parameter int BAUD_RATE = 115200,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_pin,
  output logic       uart_tx_pin,
  input  logic [2:0] addr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       irq
);
  localparam logic [15:0] DIV_RST = 16'(CLK_FRE * 1000000 / BAUD_RATE);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  logic [3:0]  ctrl_q;
  logic [15:0] div_q, eff_div;
  logic        wr_ctrl, wr_stat, wr_tx, rd_rx, tx_flush, rx_flush;
  logic        rx_ovr_q, frame_err_q, tx_ovf_q, irq_q;
  logic        rx_ovr_d, frame_err_d, tx_ovf_d, irq_d;
  logic [7:0]  tx_head, rx_head, tx_lvl, rx_lvl, stat;
  logic        tx_empty, tx_full, rx_empty, rx_full, tx_busy;

  assign wr_ctrl  = wr_en & (addr == 3'd0);
  assign wr_stat  = wr_en & (addr == 3'd1);
  assign wr_tx    = wr_en & (addr == 3'd2);
  assign rd_rx    = rd_en & (addr == 3'd3);
  assign tx_flush = wr_ctrl & wr_data[4];
  assign rx_flush = wr_ctrl & wr_data[5];
  assign eff_div  = (div_q < 16'd4) ? 16'd4 : div_q;

  // TX engine
  logic [1:0]  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_pin_q, tx_pin_d, tx_pop, tx_go, tx_bit_end;

  assign tx_go      = ctrl_q[0] & ~tx_empty;
  assign tx_bit_end = (tx_cnt_q == tx_len_q - 16'd1);
  assign tx_busy    = (tx_state_q != S_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_len_d   = tx_len_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_pin_d   = tx_pin_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (tx_go) begin
          tx_pop = 1'b1; tx_shift_d = tx_head; tx_state_d = S_START;
          tx_pin_d = 1'b0; tx_len_d = eff_div;
        end
      end
      S_START: if (tx_bit_end) begin
        tx_state_d = S_DATA; tx_pin_d = tx_shift_q[0]; tx_bit_d = '0;
        tx_cnt_d = '0; tx_len_d = eff_div;
      end
      S_DATA: if (tx_bit_end) begin
        tx_cnt_d = '0; tx_len_d = eff_div;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP; tx_pin_d = 1'b1;
        end else begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]}; tx_pin_d = tx_shift_q[1];
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      default: if (tx_bit_end) begin
        tx_cnt_d = '0; tx_len_d = eff_div;
        // Chain straight into the next start bit to avoid an idle gap.
        if (tx_go) begin
          tx_pop = 1'b1; tx_shift_d = tx_head; tx_state_d = S_START; tx_pin_d = 1'b0;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
    endcase
  end

  // RX engine
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_push, frame_set, rx_mid, rx_bit_end;

  assign rx_mid     = (rx_cnt_q == {1'b0, rx_len_q[15:1]} - 16'd1);
  assign rx_bit_end = (rx_cnt_q == rx_len_q - 16'd1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_len_d   = rx_len_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (ctrl_q[1] && rx_prev_q && !rx_s2_q) begin
          rx_state_d = S_START; rx_len_d = eff_div;
        end
      end
      S_START: if (rx_mid) begin
        rx_cnt_d = '0; rx_len_d = eff_div; rx_bit_d = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_bit_end) begin
        rx_cnt_d = '0; rx_len_d = eff_div;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else                  rx_bit_d = rx_bit_q + 3'd1;
      end
      default: if (rx_bit_end) begin
        rx_state_d = S_IDLE;
        rx_push    = rx_s2_q;
        frame_set  = ~rx_s2_q;
      end
    endcase
  end

  uart_fifo_mmio_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .flush_i(tx_flush), .push_i(wr_tx), .push_dat_i(wr_data),
    .pop_i(tx_pop), .head_o(tx_head), .lvl_o(tx_lvl), .empty_o(tx_empty), .full_o(tx_full)
  );

  uart_fifo_mmio_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .flush_i(rx_flush), .push_i(rx_push), .push_dat_i(rx_shift_q),
    .pop_i(rd_rx), .head_o(rx_head), .lvl_o(rx_lvl), .empty_o(rx_empty), .full_o(rx_full)
  );

  // Set events win over a same-cycle W1C clear.
  assign tx_ovf_d    = (wr_tx & tx_full & ~tx_pop & ~tx_flush)
                     | (tx_ovf_q & ~(wr_stat & wr_data[7]));
  assign rx_ovr_d    = (rx_push & rx_full & ~rd_rx & ~rx_flush)
                     | (rx_ovr_q & ~(wr_stat & wr_data[4]));
  assign frame_err_d = frame_set | (frame_err_q & ~(wr_stat & wr_data[5]));
  assign irq_d       = (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty & ~tx_busy)
                     | rx_ovr_q | frame_err_q | tx_ovf_q;

  assign stat = {tx_ovf_q, tx_busy, frame_err_q, rx_ovr_q, tx_full, tx_empty, rx_full, ~rx_empty};
  assign uart_tx_pin = tx_pin_q;
  assign irq = irq_q;

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      3'd0: rd_data = {4'h0, ctrl_q};
      3'd1: rd_data = stat;
      3'd3: rd_data = rx_head;
      3'd4: rd_data = div_q[7:0];
      3'd5: rd_data = div_q[15:8];
      3'd6: rd_data = tx_lvl;
      3'd7: rd_data = rx_lvl;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= 4'h3;       div_q <= DIV_RST;
      rx_ovr_q <= 1'b0;     frame_err_q <= 1'b0;  tx_ovf_q <= 1'b0;  irq_q <= 1'b0;
      tx_state_q <= S_IDLE; tx_cnt_q <= '0;  tx_len_q <= '0;  tx_shift_q <= '0;
      tx_bit_q <= '0;       tx_pin_q <= 1'b1;
      rx_s1_q <= 1'b1;      rx_s2_q <= 1'b1;      rx_prev_q <= 1'b1;
      rx_state_q <= S_IDLE; rx_cnt_q <= '0;  rx_len_q <= '0;  rx_shift_q <= '0;
      rx_bit_q <= '0;
    end else begin
      if (wr_ctrl) ctrl_q <= wr_data[3:0];
      if (wr_en && addr == 3'd4) div_q[7:0]  <= wr_data;
      if (wr_en && addr == 3'd5) div_q[15:8] <= wr_data;
      rx_ovr_q <= rx_ovr_d; frame_err_q <= frame_err_d; tx_ovf_q <= tx_ovf_d; irq_q <= irq_d;
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_len_q <= tx_len_d;
      tx_shift_q <= tx_shift_d; tx_bit_q <= tx_bit_d; tx_pin_q <= tx_pin_d;
      rx_s1_q <= uart_rx_pin; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_len_q <= rx_len_d;
      rx_shift_q <= rx_shift_d; rx_bit_q <= rx_bit_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Directed bench for uart_fifo_mmio: register reset values, TX framing, loopback, FIFO limits, errors.
module tb_uart_fifo_mmio;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       uart_rx_pin, uart_tx_pin, irq;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic [7:0] v;
  logic [7:0] b;
  logic [9:0] f1, f2;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign uart_rx_pin = loop_en ? uart_tx_pin : rx_drv;

  uart_fifo_mmio dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_pin(uart_rx_pin), .uart_tx_pin(uart_tx_pin),
    .addr(addr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data), .irq(irq)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk); addr = a; #1 d = rd_data;
  endtask

  task automatic reg_pop(output logic [7:0] d);
    @(negedge clk); addr = 3'd3; rd_en = 1'b1; #1 d = rd_data;
    @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic wait_tx_idle(input int budget);
    logic [7:0] s;
    for (int i = 0; i < budget; i++) begin
      reg_rd(3'd1, s);
      if (!s[6] && s[2]) break;
    end
    reg_rd(3'd1, s);
    check("tx_idle_wait", {7'b0, s[6]}, 8'h00);
  endtask

  initial begin
    // 1: reset values
    cycles(3);
    check("rst_tx_pin", {7'b0, uart_tx_pin}, 8'h01);
    @(negedge clk); rst_n = 1'b1;
    reg_rd(3'd0, v); check("rst_ctrl", v, 8'h03);
    reg_rd(3'd1, v); check("rst_stat", v, 8'h04);
    reg_rd(3'd4, v); check("rst_div_lo", v, 8'hEA);
    reg_rd(3'd5, v); check("rst_div_hi", v, 8'h00);
    reg_rd(3'd6, v); check("rst_txlvl", v, 8'h00);
    reg_rd(3'd7, v); check("rst_rxlvl", v, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);

    // 2: two back-to-back frames at 16 clocks per bit
    reg_wr(3'd4, 8'd16);
    @(negedge clk); addr = 3'd2; wr_data = 8'hA5; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    check("tx_lat_1cyc", {7'b0, uart_tx_pin}, 8'h01);
    @(negedge clk);
    check("tx_lat_2cyc", {7'b0, uart_tx_pin}, 8'h00);
    reg_wr(3'd2, 8'h3C);
    cycles(6);
    for (int k = 0; k < 20; k++) begin
      if (k < 10) f1[k] = uart_tx_pin;
      else        f2[k-10] = uart_tx_pin;
      if (k < 19) cycles(16);
    end
    check("frame_a5_lo", f1[7:0], 8'b01001010);
    check("frame_a5_hi", {6'b0, f1[9:8]}, 8'h03);
    check("frame_3c_lo", f2[7:0], 8'b01111000);
    check("frame_3c_hi", {6'b0, f2[9:8]}, 8'h02);
    cycles(9);
    reg_rd(3'd1, v); check("tx_done_stat", v, 8'h04);

    // 3: loopback of three bytes, then an extra pop on the empty FIFO
    loop_en = 1'b1;
    reg_wr(3'd2, 8'h00); reg_wr(3'd2, 8'hFF); reg_wr(3'd2, 8'h55);
    wait_tx_idle(800);
    reg_rd(3'd7, v); check("loop_rxlvl", v, 8'h03);
    reg_pop(v); check("loop_pop0", v, 8'h00);
    reg_pop(v); check("loop_pop1", v, 8'hFF);
    reg_pop(v); check("loop_pop2", v, 8'h55);
    reg_pop(v); check("loop_pop_empty", v, 8'h00);
    reg_rd(3'd7, v); check("loop_rxlvl_end", v, 8'h00);

    // 4: 17 bytes into a 16-entry RX FIFO
    for (int i = 0; i < 17; i++) reg_wr(3'd2, 8'h10 + 8'(i));
    wait_tx_idle(3200);
    reg_rd(3'd7, v); check("ovr_rxlvl", v, 8'h10);
    reg_rd(3'd1, v); check("ovr_stat", v, 8'h17);
    check("ovr_irq", {7'b0, irq}, 8'h01);
    reg_wr(3'd1, 8'h10);
    reg_rd(3'd1, v); check("ovr_clr_stat", v, 8'h07);
    check("ovr_clr_irq", {7'b0, irq}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      reg_pop(v); check("ovr_data", v, 8'h10 + 8'(i));
    end
    reg_rd(3'd7, v); check("ovr_rxlvl_end", v, 8'h00);

    // 5: stop bit low on 0x81, then a 3-clock glitch
    loop_en = 1'b0;
    b = 8'h81;
    @(negedge clk); rx_drv = 1'b0; cycles(16);
    for (int k = 0; k < 8; k++) begin rx_drv = b[k]; cycles(16); end
    rx_drv = 1'b0; cycles(16);
    rx_drv = 1'b1; cycles(20);
    reg_rd(3'd1, v); check("ferr_stat", v, 8'h24);
    reg_rd(3'd7, v); check("ferr_rxlvl", v, 8'h00);
    check("ferr_irq", {7'b0, irq}, 8'h01);
    reg_wr(3'd1, 8'h20);
    reg_rd(3'd1, v); check("ferr_clr_stat", v, 8'h04);
    @(negedge clk); rx_drv = 1'b0; cycles(3); rx_drv = 1'b1;
    cycles(200);
    reg_rd(3'd1, v); check("glitch_stat", v, 8'h04);
    reg_rd(3'd7, v); check("glitch_rxlvl", v, 8'h00);

    // 6: TX overflow with tx_en low, flush mid-frame, reset mid-frame
    reg_wr(3'd0, 8'h02);
    loop_en = 1'b1;
    for (int i = 0; i < 17; i++) reg_wr(3'd2, 8'h60 + 8'(i));
    reg_rd(3'd6, v); check("txovf_txlvl", v, 8'h10);
    reg_rd(3'd1, v); check("txovf_stat", v, 8'h88);
    check("txovf_irq", {7'b0, irq}, 8'h01);
    reg_wr(3'd1, 8'h80);
    reg_rd(3'd1, v); check("txovf_clr_stat", v, 8'h08);
    reg_wr(3'd0, 8'h03);
    cycles(40);
    reg_wr(3'd0, 8'h13);
    reg_rd(3'd6, v); check("flush_txlvl", v, 8'h00);
    reg_rd(3'd0, v); check("flush_ctrl", v, 8'h03);
    wait_tx_idle(400);
    reg_rd(3'd7, v); check("flush_rxlvl", v, 8'h01);
    reg_pop(v); check("flush_frame", v, 8'h60);

    reg_wr(3'd2, 8'h00);
    cycles(30);
    check("mid_frame_pin", {7'b0, uart_tx_pin}, 8'h00);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("rst_async_pin", {7'b0, uart_tx_pin}, 8'h01);
    cycles(2);
    rst_n = 1'b1;
    reg_rd(3'd4, v); check("rst2_div_lo", v, 8'hEA);
    reg_rd(3'd6, v); check("rst2_txlvl", v, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_fifo_mmio.md
Name: uart_fifo_mmio

Overview:
Second-generation memory-mapped UART for the CPU MMIO bus. It replaces the single-byte TX/RX holding registers with parametrised TX and RX FIFOs, a runtime-programmable baud divisor, sticky error flags and a level interrupt. TX and RX engines are built in, so the baud rate can change at run time. It sits on the same peripheral bus slot as the current UART.

Parameters:
CLK_FRE, 27, system clock in MHz; used only for the divisor reset value.
BAUD_RATE, 115200, baud rate; DIV resets to CLK_FRE*1000000/BAUD_RATE (234 with defaults).
TX_DEPTH, 16, TX FIFO entries; power of 2, at least 2.
RX_DEPTH, 16, RX FIFO entries; power of 2, at least 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_rx_pin  in  1  serial input (asynchronous to clk)
uart_tx_pin  out  1  serial output; idles high
addr  in  3  register select
wr_en  in  1  register write strobe, one cycle
wr_data  in  8  write data
rd_en  in  1  register read strobe; side effects only at RXDATA
rd_data  out  8  combinational read data for addr
irq  out  1  level interrupt, registered

Behaviour:
- Reset is asynchronous on rst_n low. Reset values: uart_tx_pin=1, irq=0, CTRL=0x03, DIV=default, both FIFOs empty, all sticky flags 0, both engines IDLE.
- Register map (unused bits read 0):
  - 0 CTRL (RW): b0 tx_en, b1 rx_en, b2 rx_irq_en, b3 tx_irq_en. b4 tx_flush and b5 rx_flush are write-1 pulses and always read 0.
  - 1 STAT (RO except W1C bits): b0 rx_avail, b1 rx_full, b2 tx_empty, b3 tx_full, b4 rx_overrun (W1C), b5 frame_err (W1C), b6 tx_busy, b7 tx_overflow (W1C).
  - 2 TXDATA: a write pushes wr_data; reads return 0.
  - 3 RXDATA: reads return the FIFO head (0 when empty). rd_en at this address pops one entry.
  - 4 DIV_LO and 5 DIV_HI (RW): 16-bit clocks-per-bit. Effective divisor = max(DIV,4).
  - 6 TXLVL (RO): TX FIFO occupancy. 7 RXLVL (RO): RX FIFO occupancy. Each is saturated to 8 bits.
- FIFOs:
  - Push to a full FIFO is dropped; a TX drop sets tx_overflow.
  - Pop from an empty FIFO has no effect.
  - Simultaneous push and pop in one cycle is legal: occupancy is unchanged and data order is preserved.
  - Flush zeroes pointers and occupancy in the write cycle. A frame already in flight completes; a flushed RX byte that is still in flight is written after the flush.
  - A write of 1 to a STAT W1C bit in the same cycle a set event fires leaves the flag set (set wins).
- TX engine, states IDLE, START, DATA, STOP:
  - In IDLE, when tx_en=1 and the FIFO is not empty, it pops the head into a shift register and enters START.
  - Each state lasts exactly the effective divisor clocks, latched at the start of each bit.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1. The line is driven from a flop.
  - Back-to-back bytes: STOP goes directly to START if the FIFO is not empty and tx_en=1, with no idle gap.
  - tx_busy = state != IDLE.
  - Clearing tx_en mid-frame finishes the current frame, then the engine holds in IDLE.
- RX engine, states IDLE, START, DATA, STOP:
  - uart_rx_pin passes through a 2-flop synchroniser (reset value 1).
  - In IDLE with rx_en=1, a falling edge enters START.
  - At half divisor the line is re-checked: if high, it is a glitch and the engine returns to IDLE.
  - 8 data bits are sampled at bit centres, LSB first.
  - Stop bit sampled low: frame_err is set, the byte is discarded, and the engine waits in IDLE for the line to go high.
  - Stop bit high: the byte is pushed. If the FIFO is full, the byte is dropped and rx_overrun is set.
  - Clearing rx_en mid-frame finishes the current frame.
- irq is registered:
  - irq = (rx_irq_en & rx_avail) | (tx_irq_en & tx_empty & ~tx_busy) | rx_overrun | frame_err | tx_overflow.
  - It updates one cycle after its sources.
- DIV writes take effect at the next bit boundary of each engine.
- Latency: a TXDATA write into an empty FIFO with the engine idle drives the start bit 2 cycles later.

Test Plan:
1. Reset, then read all registers. Expect CTRL=0x03, STAT=0x04, DIV=234 (0x00EA), TXLVL=0, RXLVL=0, uart_tx_pin=1.
2. Set DIV=16 and write 0xA5, 0x3C to TXDATA. Expect two back-to-back frames on uart_tx_pin, each bit 16 clocks: 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1, with no gap. tx_empty=1 after the final stop bit.
3. Loop uart_tx_pin to uart_rx_pin. Send 0x00, 0xFF, 0x55. Expect RXLVL=3, then RXDATA pops return 0x00, 0xFF, 0x55; a 4th pop returns 0 and RXLVL stays 0.
4. With RX_DEPTH=16 and no reads, receive 17 bytes. Expect rx_full=1 and rx_overrun=1, bytes 1-16 intact, irq=1. Write 0x10 to STAT: rx_overrun clears.
5. Drive a frame with stop bit 0 (byte 0x81). Expect frame_err=1 and RXLVL unchanged. Drive a 3-clock low glitch at DIV=16: no byte, no error.
6. Write 17 bytes with tx_en=0. Expect TXLVL=16 and tx_overflow=1. Then a tx_flush mid-stream: TXLVL=0 and the current frame completes intact. Assert rst_n mid-frame: uart_tx_pin goes to 1 immediately.
